// File: rtl/abs_sample_collector.sv
// ---------------------------------------------------------------------------
// abs_sample_collector
//
// Collects one signed 16-bit sample per channel (8 channels, any arrival
// order), converts each to a saturated 15-bit absolute value and, once all
// eight channels of a frame have arrived, publishes them together on
// abs_sample_concat with a one-cycle frame_valid pulse. After WARMUP_FRAMES
// complete frames sample_core_done asserts. A repeated channel within a frame
// or a frame that takes TIMEOUT_CYCLES cycles without completing locks the
// block in ERROR until reset.
//
// Parameters
//   WARMUP_FRAMES     frames needed before sample_core_done (1..255)
//   TIMEOUT_CYCLES    max cycles from a frame's first sample to completion
//                     (8..65535)
// Ports
//   clk               rising-edge system clock
//   resetn            asynchronous active-low reset
//   enable            level; high runs the collector, low returns to IDLE
//   sample_valid      sample_ch/sample_data valid this cycle
//   sample_ch         channel index 0..7
//   sample_data       signed two's-complement sample
//   abs_sample_concat channel i absolute value at bits [15i+14:15i]
//   frame_valid       one-cycle pulse when abs_sample_concat updates
//   sample_core_done  level; warmup complete
//   err_dup_ch        sticky; channel repeated within a frame
//   err_timeout       sticky; frame did not complete in time
// ---------------------------------------------------------------------------
module abs_sample_collector #(
    parameter int unsigned WARMUP_FRAMES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         enable,
    input  logic         sample_valid,
    input  logic [2:0]   sample_ch,
    input  logic [15:0]  sample_data,
    output logic [119:0] abs_sample_concat,
    output logic         frame_valid,
    output logic         sample_core_done,
    output logic         err_dup_ch,
    output logic         err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUNNING,
        ERROR
    } state_t;

    // The timeout fires on the edge where the counter would reach
    // TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES edges after the first sample.
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  WARM_LAST = 8'(WARMUP_FRAMES);

    state_t         state_q;
    logic [7:0]     mask_q;
    logic [15:0]    tmo_q;
    logic [7:0]     frame_cnt_q;
    logic [14:0]    shadow_q [8];
    logic [119:0]   concat_q;
    logic           fv_q;
    logic           done_q;
    logic           dup_err_q;
    logic           tmo_err_q;

    // Combinational helpers for the current cycle's sample
    logic [14:0]    neg_d;
    logic [14:0]    abs_d;
    logic [7:0]     onehot_d;
    logic [7:0]     mask_d;
    logic           dup_d;
    logic           accept_d;
    logic           complete_d;
    logic           tmo_hit_d;
    logic [7:0]     frame_cnt_d;
    logic           warm_last_d;
    logic [119:0]   frame_d;

    always_comb begin
        // 15-bit negation of the low bits equals the low bits of the full
        // negation; only -32768 needs saturating.
        neg_d = (~sample_data[14:0]) + 15'd1;
        if (!sample_data[15]) begin
            abs_d = sample_data[14:0];
        end else if (sample_data == 16'h8000) begin
            abs_d = 15'h7FFF;
        end else begin
            abs_d = neg_d;
        end

        onehot_d    = 8'd1 << sample_ch;
        mask_d      = mask_q | onehot_d;
        dup_d       = sample_valid && mask_q[sample_ch];
        accept_d    = sample_valid && !mask_q[sample_ch];
        complete_d  = accept_d && (mask_d == 8'hFF);
        tmo_hit_d   = (mask_q != 8'h00) && (tmo_q == TMO_LAST);
        frame_cnt_d = frame_cnt_q + 8'd1;
        warm_last_d = (frame_cnt_d == WARM_LAST);

        // Completed frame includes the sample being accepted this edge
        frame_d = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            frame_d[15*i +: 15] = (3'(i) == sample_ch) ? abs_d : shadow_q[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            tmo_q       <= '0;
            frame_cnt_q <= '0;
            concat_q    <= '0;
            fv_q        <= 1'b0;
            done_q      <= 1'b0;
            dup_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            fv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q     <= WARMUP;
                        mask_q      <= '0;
                        tmo_q       <= '0;
                        frame_cnt_q <= '0;
                    end
                end

                WARMUP, RUNNING: begin
                    if (!enable) begin
                        state_q     <= IDLE;
                        mask_q      <= '0;
                        tmo_q       <= '0;
                        frame_cnt_q <= '0;
                        done_q      <= 1'b0;
                    end else if (dup_d || (tmo_hit_d && !complete_d)) begin
                        // Completion beats timeout; dup and timeout together
                        // raise both flags.
                        state_q <= ERROR;
                        if (dup_d) begin
                            dup_err_q <= 1'b1;
                        end
                        if (tmo_hit_d) begin
                            tmo_err_q <= 1'b1;
                        end
                    end else begin
                        if (complete_d) begin
                            tmo_q <= '0;
                        end else if (mask_q != 8'h00) begin
                            tmo_q <= tmo_q + 16'd1;
                        end

                        if (accept_d) begin
                            shadow_q[sample_ch] <= abs_d;
                            mask_q <= complete_d ? 8'h00 : mask_d;
                        end

                        if (complete_d) begin
                            concat_q <= frame_d;
                            fv_q     <= 1'b1;
                            if (state_q == WARMUP) begin
                                frame_cnt_q <= frame_cnt_d;
                                if (warm_last_d) begin
                                    done_q  <= 1'b1;
                                    state_q <= RUNNING;
                                end
                            end
                        end
                    end
                end

                ERROR: begin
                    // Terminal until reset
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign abs_sample_concat = concat_q;
    assign frame_valid       = fv_q;
    assign sample_core_done  = done_q;
    assign err_dup_ch        = dup_err_q;
    assign err_timeout       = tmo_err_q;

endmodule

// File: tb/tb_abs_sample_collector.sv
// ---------------------------------------------------------------------------
// tb_abs_sample_collector
//
// Directed bench for abs_sample_collector with default parameters
// (WARMUP_FRAMES=4, TIMEOUT_CYCLES=64). Two hand-computed frames live in a
// vector table; multi-cycle corner cases (duplicate channel, timeout, enable
// drop, asynchronous reset) are written out as sequences.
// ---------------------------------------------------------------------------
module tb_abs_sample_collector;

    logic         clk;
    logic         resetn;
    logic         enable;
    logic         sample_valid;
    logic [2:0]   sample_ch;
    logic [15:0]  sample_data;
    logic [119:0] abs_sample_concat;
    logic         frame_valid;
    logic         sample_core_done;
    logic         err_dup_ch;
    logic         err_timeout;

    abs_sample_collector #(
        .WARMUP_FRAMES (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .enable           (enable),
        .sample_valid     (sample_valid),
        .sample_ch        (sample_ch),
        .sample_data      (sample_data),
        .abs_sample_concat(abs_sample_concat),
        .frame_valid      (frame_valid),
        .sample_core_done (sample_core_done),
        .err_dup_ch       (err_dup_ch),
        .err_timeout      (err_timeout)
    );

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] data;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl [16];

    int errors = 0;
    int checks = 0;
    int fv_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn && frame_valid) fv_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [2:0] ch, input logic [15:0] data);
        sample_valid = 1'b1;
        sample_ch    = ch;
        sample_data  = data;
        tick();
        sample_valid = 1'b0;
    endtask

    // Sends one table frame starting at base; rev sends entries last-first.
    task automatic send_frame(input int base, input bit rev, input int gap);
        int idx;
        for (int j = 0; j < 8; j++) begin
            idx = rev ? base + 7 - j : base + j;
            send_sample(tbl[idx].ch, tbl[idx].data);
            if (j < 7) repeat (gap) tick();
        end
        chk("frame_valid_pulse", frame_valid, 1);
        tick();
        chk("frame_valid_one_cycle", frame_valid, 0);
    endtask

    task automatic check_concat(input int base, input string name);
        int lsb;
        for (int j = 0; j < 8; j++) begin
            lsb = 15 * int'(tbl[base + j].ch);
            chk(name, abs_sample_concat[lsb +: 15], tbl[base + j].exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_concat"}, abs_sample_concat, 0);
        chk({tag, "_frame_valid"}, frame_valid, 0);
        chk({tag, "_core_done"}, sample_core_done, 0);
        chk({tag, "_err_dup"}, err_dup_ch, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        check_all_zero("reset");
        resetn = 1'b1;
        tick();   // enable is high: IDLE -> WARMUP on this edge
    endtask

    initial begin
        int k;
        int fv_before;

        // Frame A: channels 0..7 in order
        tbl[0]  = '{3'd0, 16'd100,   15'd100};
        tbl[1]  = '{3'd1, 16'hFF38,  15'd200};
        tbl[2]  = '{3'd2, 16'd300,   15'd300};
        tbl[3]  = '{3'd3, 16'h8000,  15'h7FFF};
        tbl[4]  = '{3'd4, 16'h0000,  15'd0};
        tbl[5]  = '{3'd5, 16'hFFFF,  15'd1};
        tbl[6]  = '{3'd6, 16'h7FFF,  15'h7FFF};
        tbl[7]  = '{3'd7, 16'hFFFB,  15'd5};
        // Frame B: boundary values in scrambled channel order
        tbl[8]  = '{3'd5, 16'h4000,  15'h4000};
        tbl[9]  = '{3'd2, 16'hFFFE,  15'd2};
        tbl[10] = '{3'd7, 16'h1234,  15'h1234};
        tbl[11] = '{3'd0, 16'h7FFF,  15'h7FFF};
        tbl[12] = '{3'd6, 16'h8000,  15'h7FFF};
        tbl[13] = '{3'd1, 16'h8001,  15'h7FFF};
        tbl[14] = '{3'd4, 16'hC000,  15'h4000};
        tbl[15] = '{3'd3, 16'h0001,  15'd1};

        resetn       = 1'b0;
        enable       = 1'b1;
        sample_valid = 1'b0;
        sample_ch    = '0;
        sample_data  = '0;
        #3;
        do_reset();

        // Warmup: four frames, one sample every two cycles
        fv_before = fv_cnt;
        for (int f = 0; f < 4; f++) begin
            send_frame(0, 1'b0, 1);
            chk("warmup_core_done", sample_core_done, (f == 3));
            check_concat(0, "warmup_concat");
        end
        chk("warmup_pulse_count", fv_cnt - fv_before, 4);

        // RUNNING: scrambled boundary frame, then frame A in order 7..0
        send_frame(8, 1'b0, 1);
        check_concat(8, "frameB_concat");
        send_frame(0, 1'b1, 1);
        check_concat(0, "reverse_concat");
        chk("running_core_done", sample_core_done, 1);

        // Duplicate channel 3 before channel 5
        for (int j = 0; j < 4; j++) send_sample(tbl[j].ch, tbl[j].data);
        send_sample(3'd3, 16'd77);
        chk("dup_err_dup", err_dup_ch, 1);
        chk("dup_err_timeout", err_timeout, 0);
        fv_before = fv_cnt;
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        for (int j = 4; j < 8; j++) send_sample(tbl[j].ch, tbl[j].data);
        repeat (3) tick();
        chk("error_no_frame_valid", fv_cnt - fv_before, 0);
        chk("error_core_done_held", sample_core_done, 1);
        chk("error_err_dup_sticky", err_dup_ch, 1);
        check_concat(0, "error_concat_held");

        // Timeout: seven channels then stall
        do_reset();
        send_sample(3'd0, 16'd1);
        k = 0;
        for (int j = 1; j < 7; j++) begin
            send_sample(3'(j), 16'd1);
            k++;
        end
        while (k < 63) begin
            tick();
            k++;
        end
        chk("timeout_not_yet", err_timeout, 0);
        tick();
        chk("timeout_at_64", err_timeout, 1);
        chk("timeout_no_dup", err_dup_ch, 0);

        // Eighth sample lands on the timeout edge: completion wins
        do_reset();
        send_sample(3'd0, 16'd9);
        k = 0;
        for (int j = 1; j < 7; j++) begin
            send_sample(3'(j), 16'd9);
            k++;
        end
        while (k < 63) begin
            tick();
            k++;
        end
        send_sample(3'd7, 16'hFFF7);
        chk("tmo_edge_frame_valid", frame_valid, 1);
        chk("tmo_edge_no_err", err_timeout, 0);
        chk("tmo_edge_ch7", abs_sample_concat[119:105], 15'd9);
        repeat (3) tick();
        chk("tmo_edge_no_err_later", err_timeout, 0);

        // Enable dropped after two warmup frames
        do_reset();
        send_frame(0, 1'b0, 1);
        send_frame(0, 1'b0, 1);
        chk("drop_pre_core_done", sample_core_done, 0);
        for (int j = 8; j < 11; j++) send_sample(tbl[j].ch, tbl[j].data);
        fv_before = fv_cnt;
        enable = 1'b0;
        send_sample(tbl[11].ch, tbl[11].data);
        chk("drop_core_done", sample_core_done, 0);
        check_concat(0, "drop_concat_held");
        enable = 1'b1;
        tick();
        send_frame(8, 1'b0, 1);
        chk("rewarm1_core_done", sample_core_done, 0);
        send_frame(0, 1'b0, 1);
        chk("rewarm2_core_done", sample_core_done, 0);
        send_frame(8, 1'b0, 1);
        chk("rewarm3_core_done", sample_core_done, 0);
        send_frame(0, 1'b0, 1);
        chk("rewarm4_core_done", sample_core_done, 1);
        chk("rewarm_pulse_count", fv_cnt - fv_before, 4);
        chk("rewarm_no_dup", err_dup_ch, 0);
        check_concat(0, "rewarm_concat");

        // Asynchronous reset mid-frame in RUNNING
        for (int j = 0; j < 3; j++) send_sample(tbl[j].ch, tbl[j].data);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        resetn = 1'b1;
        tick();
        send_frame(8, 1'b0, 1);
        check_concat(8, "post_reset_concat");
        chk("post_reset_core_done", sample_core_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
